// File: rtl/sha256_iter_core_if.sv
// sha256_iter_core_if
//   Job/result handshake bundle for the iterative SHA-256 compression core.
//   in_valid/in_ready   : job handshake (in_state, in_block, in_tag)
//   out_valid/out_ready : result handshake (out_hash, out_tag)
//   Packing: 32-bit word n at bits [32n+31:32n]; in_state word 0 = a.
//   master : job producer and result consumer
//   slave  : the core
interface sha256_iter_core_if #(
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [255:0]     in_state;
  logic [511:0]     in_block;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [255:0]     out_hash;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_state, in_block, in_tag, out_ready,
    input  in_ready, out_valid, out_hash, out_tag
  );

  modport slave (
    input  in_valid, in_state, in_block, in_tag, out_ready,
    output in_ready, out_valid, out_hash, out_tag
  );
endinterface

// File: rtl/sha256_iter_core.sv
// sha256_iter_core
//   Iterative SHA-256 compression of one 512-bit block, UNROLL rounds per clock.
//   Parameters: UNROLL  rounds per clock (1,2,4,8,16,32,64)
//               FEEDFWD 1 = result is H + working state, 0 = working state only
//               TAG_W   width of the opaque job tag
//   Ports:      clk   rising-edge clock
//               rst_n synchronous active-low reset
//               bus   job/result handshake (sha256_iter_core_if.slave)
//   Latency: out_valid rises 64/UNROLL+1 edges after the accept edge.
module sha256_iter_core #(
  parameter int UNROLL  = 1,
  parameter int FEEDFWD = 1,
  parameter int TAG_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sha256_iter_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

  state_t           state_r;
  logic [6:0]       rcnt_r;
  logic [31:0]      ff_r   [8];
  logic [31:0]      work_r [8];
  logic [31:0]      w_r    [16];
  logic             out_valid_r;
  logic [255:0]     out_hash_r;
  logic [TAG_W-1:0] out_tag_r;
  logic [TAG_W-1:0] tag_r;

  logic             in_ready_s;
  logic             accept_s;
  logic [31:0]      a_s    [8];
  logic [31:0]      w_s    [16];
  logic [255:0]     hash_s;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] k_const(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = 32'h00000000;
    endcase
    return k;
  endfunction

  // Ready is held low through reset so nothing is accepted before the FSM is clean.
  assign in_ready_s    = rst_n && ((state_r == IDLE) || ((state_r == DONE) && bus.out_ready));
  assign accept_s      = bus.in_valid && in_ready_s;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_hash  = out_hash_r;
  assign bus.out_tag   = out_tag_r;

  // UNROLL chained rounds plus message-schedule shifts for the next RUN edge
  always_comb begin
    logic [31:0] t1_s, t2_s, nw_s;
    logic [5:0]  kidx_s;
    for (int i = 0; i < 8; i++) a_s[i] = work_r[i];
    for (int j = 0; j < 16; j++) w_s[j] = w_r[j];
    for (int r = 0; r < UNROLL; r++) begin
      kidx_s = rcnt_r[5:0] + 6'(r);
      t1_s = a_s[7] + bsig1(a_s[4]) + ch(a_s[4], a_s[5], a_s[6]) + w_s[0] + k_const(kidx_s);
      t2_s = bsig0(a_s[0]) + maj(a_s[0], a_s[1], a_s[2]);
      for (int i = 7; i > 0; i--) a_s[i] = a_s[i-1];
      a_s[4] = a_s[4] + t1_s;  // slot 4 now holds old d: e' = d + T1
      a_s[0] = t1_s + t2_s;
      nw_s = ssig1(w_s[14]) + w_s[9] + ssig0(w_s[1]) + w_s[0];
      for (int j = 0; j < 15; j++) w_s[j] = w_s[j+1];
      w_s[15] = nw_s;
    end
  end

  // Result word formation, with or without the feed-forward add
  always_comb begin
    hash_s = 256'd0;
    for (int i = 0; i < 8; i++) begin
      if (FEEDFWD != 0) hash_s[32*i +: 32] = ff_r[i] + work_r[i];
      else              hash_s[32*i +: 32] = work_r[i];
    end
  end

  // Control FSM, job latching, round state and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rcnt_r      <= 7'd0;
      out_valid_r <= 1'b0;
      out_hash_r  <= 256'd0;
      out_tag_r   <= {TAG_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) state_r <= RUN;
          else          state_r <= IDLE;
        end
        RUN: begin
          for (int i = 0; i < 8; i++) work_r[i] <= a_s[i];
          for (int j = 0; j < 16; j++) w_r[j] <= w_s[j];
          rcnt_r <= rcnt_r + 7'(UNROLL);
          if ((rcnt_r + 7'(UNROLL)) == 7'd64) state_r <= FIN;
          else                                state_r <= RUN;
        end
        FIN: begin
          out_hash_r  <= hash_s;
          out_tag_r   <= tag_r;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= bus.in_valid ? RUN : IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: state_r <= IDLE;
      endcase
      // Accept only happens in IDLE or draining DONE, never overlapping RUN updates.
      if (accept_s) begin
        for (int i = 0; i < 8; i++) begin
          ff_r[i]   <= bus.in_state[32*i +: 32];
          work_r[i] <= bus.in_state[32*i +: 32];
        end
        for (int j = 0; j < 16; j++) w_r[j] <= bus.in_block[32*j +: 32];
        tag_r  <= bus.in_tag;
        rcnt_r <= 7'd0;
      end
    end
  end

endmodule
